// File: rtl/bsg_sha_pkg.sv
// Shared definitions for the miner's result-sequencing logic.
//   HashWidth   - width of one double-SHA result
//   TargetWidth - width of the difficulty target and of the compared hash word
//   CountWidth  - width of the checked-results counter
//   state_e     - target-check arbiter FSM states
package bsg_sha_pkg;

    localparam int unsigned HashWidth   = 256;
    localparam int unsigned TargetWidth = 32;
    localparam int unsigned CountWidth  = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCheck = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/bsg_target_check_arbiter_if.sv
// Bundle between the SHA core array, the target-check arbiter and the result collector.
// Names are from the arbiter's point of view.
//   core side  : v_i, data_i, nonce_i (from cores), yumi_o (to cores, one-hot)
//   result side: v_o, found_o, nonce_o, core_id_o (to collector), yumi_i (from collector)
// Modports:
//   slave  - the arbiter
//   master - the environment (cores + collector)
interface bsg_target_check_arbiter_if #(
    parameter int unsigned num_cores_p   = 4,
    parameter int unsigned nonce_width_p = 32
);
    import bsg_sha_pkg::*;

    localparam int unsigned id_width_lp = $clog2(num_cores_p);

    logic [num_cores_p-1:0]               v_i;
    logic [num_cores_p*HashWidth-1:0]     data_i;
    logic [num_cores_p*nonce_width_p-1:0] nonce_i;
    logic [num_cores_p-1:0]               yumi_o;

    logic                     v_o;
    logic                     found_o;
    logic [nonce_width_p-1:0] nonce_o;
    logic [id_width_lp-1:0]   core_id_o;
    logic                     yumi_i;

    modport slave (
        input  v_i, data_i, nonce_i, yumi_i,
        output yumi_o, v_o, found_o, nonce_o, core_id_o
    );

    modport master (
        output v_i, data_i, nonce_i, yumi_i,
        input  yumi_o, v_o, found_o, nonce_o, core_id_o
    );

endinterface

// File: rtl/bsg_rr_pick.sv
// Combinational round-robin picker.
//   v_i     - request vector
//   ptr_i   - highest-priority index this cycle
//   grant_o - one-hot grant: first set request scanning upward from ptr_i with wrap
//   id_o    - encoded index of the granted request (0 when none)
//   any_o   - at least one request is set
// num_cores_p must be a power of two so the index addition wraps naturally.
module bsg_rr_pick #(
    parameter  int unsigned num_cores_p = 4,
    localparam int unsigned id_width_lp = $clog2(num_cores_p)
) (
    input  logic [num_cores_p-1:0] v_i,
    input  logic [id_width_lp-1:0] ptr_i,
    output logic [num_cores_p-1:0] grant_o,
    output logic [id_width_lp-1:0] id_o,
    output logic                   any_o
);

    logic                   hit;
    logic [id_width_lp-1:0] idx;

    always_comb begin
        grant_o = '0;
        id_o    = '0;
        hit     = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < num_cores_p; i++) begin
            idx = ptr_i + id_width_lp'(i);
            if (!hit && v_i[idx]) begin
                hit          = 1'b1;
                grant_o[idx] = 1'b1;
                id_o         = idx;
            end
        end
    end

    assign any_o = |v_i;

endmodule

// File: rtl/bsg_target_check_arbiter.sv
// Shares one target-compare stage between num_cores_p SHA cores.
//   clk_i, reset_i  - clock, synchronous active-high reset
//   target_v_i      - load target_i into the target register
//   target_i        - difficulty target (unsigned)
//   checked_count_o - results compared since reset (wraps)
//   bus_io          - core-side request/consume and result-side handshake
// Flow: IDLE grants one core round-robin and snapshots its hash word, nonce and the
// current target; CHECK does the strict unsigned compare; DONE holds the result until
// the collector consumes it, then advances the round-robin pointer past the winner.
module bsg_target_check_arbiter
    import bsg_sha_pkg::*;
#(
    parameter  int unsigned num_cores_p   = 4,
    parameter  int unsigned nonce_width_p = 32,
    localparam int unsigned id_width_lp   = $clog2(num_cores_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   target_v_i,
    input  logic [TargetWidth-1:0] target_i,
    output logic [CountWidth-1:0]  checked_count_o,
    bsg_target_check_arbiter_if.slave bus_io
);

    state_e                   state_q, state_d;
    logic [id_width_lp-1:0]   rr_ptr_q, rr_ptr_d;
    logic [id_width_lp-1:0]   id_q, id_d;
    logic [TargetWidth-1:0]   word_q, word_d;
    logic [TargetWidth-1:0]   snap_q, snap_d;
    logic [TargetWidth-1:0]   target_q, target_d;
    logic [CountWidth-1:0]    count_q, count_d;
    logic [nonce_width_p-1:0] nonce_q, nonce_d;
    logic                     found_q, found_d;

    logic [num_cores_p-1:0]   grant;
    logic [id_width_lp-1:0]   grant_id;
    logic                     grant_any;
    logic [TargetWidth-1:0]   grant_word;
    logic [nonce_width_p-1:0] grant_nonce;
    logic [num_cores_p-1:0]   yumi;

    bsg_rr_pick #(
        .num_cores_p(num_cores_p)
    ) u_pick (
        .v_i    (bus_io.v_i),
        .ptr_i  (rr_ptr_q),
        .grant_o(grant),
        .id_o   (grant_id),
        .any_o  (grant_any)
    );

    // One-hot AND-OR mux; only the low word of each hash takes part in the compare.
    always_comb begin
        grant_word  = '0;
        grant_nonce = '0;
        for (int unsigned k = 0; k < num_cores_p; k++) begin
            if (grant[k]) begin
                grant_word  = grant_word  | bus_io.data_i[k*HashWidth +: TargetWidth];
                grant_nonce = grant_nonce | bus_io.nonce_i[k*nonce_width_p +: nonce_width_p];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        word_d   = word_q;
        snap_d   = snap_q;
        count_d  = count_q;
        nonce_d  = nonce_q;
        found_d  = found_q;
        yumi     = '0;
        target_d = target_v_i ? target_i : target_q;

        unique case (state_q)
            StIdle: begin
                if (grant_any) begin
                    yumi    = grant;
                    word_d  = grant_word;
                    nonce_d = grant_nonce;
                    id_d    = grant_id;
                    // Snapshot before any load this cycle takes effect.
                    snap_d  = target_q;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                found_d = (word_q < snap_q);
                count_d = count_q + 32'd1;
                state_d = StDone;
            end
            StDone: begin
                if (bus_io.yumi_i) begin
                    rr_ptr_d = id_q + id_width_lp'(1);
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            id_q     <= '0;
            word_q   <= '0;
            snap_q   <= '0;
            target_q <= '0;
            count_q  <= '0;
            nonce_q  <= '0;
            found_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            word_q   <= word_d;
            snap_q   <= snap_d;
            target_q <= target_d;
            count_q  <= count_d;
            nonce_q  <= nonce_d;
            found_q  <= found_d;
        end
    end

    // A core must never see a consume while the block is being reset.
    assign bus_io.yumi_o    = reset_i ? '0 : yumi;
    assign bus_io.v_o       = (state_q == StDone);
    assign bus_io.found_o   = found_q;
    assign bus_io.nonce_o   = nonce_q;
    assign bus_io.core_id_o = id_q;
    assign checked_count_o  = count_q;

endmodule
